// File: rtl/flash_cmd_model.sv
// flash_cmd_model: clocked parallel NOR flash model with command set, busy timing and status.
// Define FLASH_CMD_LOG_EN to log commands, commits, errors and aborts with $time.
module flash_cmd_model #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BLOCK_W   = 4,
    parameter int PROG_CYC  = 8,
    parameter int ERASE_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] NF_A,
    inout  wire  [DATA_W-1:0] NF_D,
    input  logic              NF_CE,
    input  logic              NF_OE,
    input  logic              NF_WE,
    input  logic              NF_RP,
    input  logic              NF_WP,
    output logic              NF_STS
);

    localparam int WORDS  = 2 ** ADDR_W;
    localparam int BWORDS = 2 ** BLOCK_W;
    localparam int BLK_W  = ADDR_W - BLOCK_W;
    localparam int MAXC   = (PROG_CYC > ERASE_CYC) ? PROG_CYC : ERASE_CYC;
    localparam int CNT_W  = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        READ_ARRAY,
        READ_STATUS,
        PROG_SETUP,
        ERASE_SETUP,
        BUSY_PROG,
        BUSY_ERASE
    } mode_t;

    logic [1:0]        ce_sq, we_sq, oe_sq, rp_sq;
    logic              we_pq;
    logic [ADDR_W-1:0] cap_a_q;
    logic [DATA_W-1:0] cap_d_q;
    mode_t             mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        err_q, err_d;
    logic [ADDR_W-1:0] pa_q, pa_d;
    logic [DATA_W-1:0] pd_q, pd_d;
    logic [BLK_W-1:0]  blk_q, blk_d;

    logic              cap_en, wr_ev, busy, prog_go, erase_go, rd_en;
    logic [7:0]        cmd, stat8;
    logic [DATA_W-1:0] rdata;

    // Stored inverted: 2-state zero at time 0 reads back as erased all-ones.
    bit [DATA_W-1:0] memn_q [WORDS];

    // A WE strobe while OE is asserted is bus contention, not a write.
    assign cap_en = !ce_sq[1] && !we_sq[1] && oe_sq[1];
    assign wr_ev  = we_sq[1] && !we_pq && !ce_sq[1];
    assign cmd    = cap_d_q[7:0];
    assign busy   = (mode_q == BUSY_PROG) || (mode_q == BUSY_ERASE);
    assign NF_STS = !busy;
    assign stat8  = {!busy, 1'b0, err_q[2], err_q[1], 2'b00, err_q[0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_sq   <= '1;
            we_sq   <= '1;
            oe_sq   <= '1;
            rp_sq   <= '1;
            we_pq   <= 1'b1;
            cap_a_q <= '0;
            cap_d_q <= '0;
            mode_q  <= READ_ARRAY;
            cnt_q   <= '0;
            err_q   <= '0;
            pa_q    <= '0;
            pd_q    <= '0;
            blk_q   <= '0;
        end else begin
            ce_sq   <= {ce_sq[0], NF_CE};
            we_sq   <= {we_sq[0], NF_WE};
            oe_sq   <= {oe_sq[0], NF_OE};
            rp_sq   <= {rp_sq[0], NF_RP};
            we_pq   <= we_sq[1];
            if (cap_en) begin
                cap_a_q <= NF_A;
                cap_d_q <= NF_D;
            end
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pa_q    <= pa_d;
            pd_q    <= pd_d;
            blk_q   <= blk_d;
        end
    end

    // err bits: [2] erase error (bit5), [1] program error (bit4), [0] protect (bit1)
    always_comb begin
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pa_d     = pa_q;
        pd_d     = pd_q;
        blk_d    = blk_q;
        prog_go  = 1'b0;
        erase_go = 1'b0;
        unique case (mode_q)
            BUSY_PROG, BUSY_ERASE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mode_d   = READ_STATUS;
                    prog_go  = (mode_q == BUSY_PROG);
                    erase_go = (mode_q == BUSY_ERASE);
                end
            end
            PROG_SETUP: begin
                if (wr_ev) begin
                    if (!NF_WP) begin
                        err_d[1] = 1'b1;
                        err_d[0] = 1'b1;
                        mode_d   = READ_STATUS;
                    end else begin
                        mode_d = BUSY_PROG;
                        cnt_d  = CNT_W'(PROG_CYC);
                        pa_d   = cap_a_q;
                        pd_d   = cap_d_q;
                    end
                end
            end
            ERASE_SETUP: begin
                if (wr_ev) begin
                    mode_d = READ_STATUS;
                    if (cmd != 8'hD0) begin
                        err_d[2] = 1'b1;
                        err_d[1] = 1'b1;
                    end else if (!NF_WP) begin
                        err_d[2] = 1'b1;
                        err_d[0] = 1'b1;
                    end else begin
                        mode_d = BUSY_ERASE;
                        cnt_d  = CNT_W'(ERASE_CYC);
                        blk_d  = cap_a_q[ADDR_W-1:BLOCK_W];
                    end
                end
            end
            default: begin
                if (wr_ev) begin
                    unique case (cmd)
                        8'hFF:        mode_d = READ_ARRAY;
                        8'h70:        mode_d = READ_STATUS;
                        8'h50:        err_d  = '0;
                        8'h40, 8'h10: mode_d = PROG_SETUP;
                        8'h20:        mode_d = ERASE_SETUP;
                        default:      ;
                    endcase
                end
            end
        endcase
        if (!rp_sq[1]) begin
            mode_d   = READ_ARRAY;
            cnt_d    = '0;
            err_d    = '0;
            prog_go  = 1'b0;
            erase_go = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_go)
            memn_q[pa_q] <= memn_q[pa_q] | ~pd_q;
        if (erase_go)
            for (int i = 0; i < BWORDS; i++)
                memn_q[{blk_q, BLOCK_W'(i)}] <= '0;
    end

    assign rd_en = !NF_CE && !NF_OE && NF_RP && NF_WE;
    assign rdata = (mode_q == READ_ARRAY) ? ~memn_q[NF_A] : DATA_W'(stat8);
    assign NF_D  = rd_en ? rdata : 'z;

`ifdef FLASH_CMD_LOG_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (wr_ev && !busy && rp_sq[1])
                $display("%0t flash_cmd_model: write %h in %s",
                         $time, cap_d_q, mode_q.name());
            if (prog_go)
                $display("%0t flash_cmd_model: program [%h] %h -> %h",
                         $time, pa_q, ~memn_q[pa_q], ~(memn_q[pa_q] | ~pd_q));
            if (erase_go)
                $display("%0t flash_cmd_model: erase block %0d", $time, blk_q);
            if (rp_sq[1] && wr_ev && (mode_q == PROG_SETUP || mode_q == ERASE_SETUP)
                && mode_d == READ_STATUS)
                $display("%0t flash_cmd_model: protect/sequence error, status %h",
                         $time, {!busy, 1'b0, err_d[2], err_d[1], 2'b00, err_d[0], 1'b0});
            if (!rp_sq[1] && busy)
                $display("%0t flash_cmd_model: %s aborted by NF_RP", $time, mode_q.name());
        end
    end

    always @(posedge rst)
        $display("%0t flash_cmd_model: reset, any operation aborted", $time);
`else
    // silent build
`endif

endmodule

// File: tb/tb_flash_cmd_model.sv
// Scoreboard bench for flash_cmd_model: random command traffic against a
// word-level reference model; monitors compare reads and busy lengths.
module tb_flash_cmd_model;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int BLOCK_W   = 4;
    localparam int PROG_CYC  = 8;
    localparam int ERASE_CYC = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = 8'h00;
    logic       ce  = 1'b1;
    logic       oe  = 1'b1;
    logic       we  = 1'b1;
    logic       rp  = 1'b1;
    logic       wp  = 1'b1;
    logic       sts;
    logic [7:0] tb_d = 8'h00;
    logic       tb_drv = 1'b0;
    wire  [7:0] nf_d;

    assign nf_d = tb_drv ? tb_d : 'z;

    always #5 clk = ~clk;

    flash_cmd_model #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_W(BLOCK_W),
        .PROG_CYC(PROG_CYC), .ERASE_CYC(ERASE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .NF_A(a), .NF_D(nf_d),
        .NF_CE(ce), .NF_OE(oe), .NF_WE(we), .NF_RP(rp),
        .NF_WP(wp), .NF_STS(sts)
    );

    typedef struct {
        bit         is_sts;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t rd_q[$];
    int   busy_q[$];
    int   checks = 0;
    int   errors = 0;
    logic strobe = 1'b0;
    int   run = 0;

    // reference model: whole-word view of the flash, ops applied on completion
    logic [7:0] mem_m [256];
    bit         m_arr;
    int         m_phase;
    logic [7:0] m_err;
    bit         m_busy;
    int         m_pk;
    logic [7:0] m_pa, m_pd;

    always @(negedge clk) begin
        if (strobe) begin
            exp_t       e;
            logic [7:0] got;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: no expectation queued");
            end else begin
                e = rd_q.pop_front();
                checks++;
                got = e.is_sts ? {7'b0, sts} : nf_d;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
        end
    end

    // busy pulse lengths; -1 marks an aborted operation that must end early
    always @(negedge clk) begin
        if (!rst) begin
            if (sts === 1'b0) begin
                run++;
            end else if (run != 0) begin
                if (busy_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_busy: length %0d", run);
                end else begin
                    int exp_len;
                    exp_len = busy_q.pop_front();
                    checks++;
                    if (exp_len < 0 ? (run >= ERASE_CYC) : (run != exp_len)) begin
                        errors++;
                        $display("FAIL busy_len: got %0d cycles expected %0d", run, exp_len);
                    end
                end
                run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [7:0] ad, input logic [7:0] dd);
        if (m_busy) return;
        case (m_phase)
            1: begin
                m_phase = 0;
                m_arr   = 0;
                if (!wp) begin
                    m_err = m_err | 8'h12;
                end else begin
                    m_busy = 1;
                    m_pk   = 1;
                    m_pa   = ad;
                    m_pd   = dd;
                    busy_q.push_back(PROG_CYC);
                end
            end
            2: begin
                m_phase = 0;
                m_arr   = 0;
                if (dd != 8'hD0) begin
                    m_err = m_err | 8'h30;
                end else if (!wp) begin
                    m_err = m_err | 8'h22;
                end else begin
                    m_busy = 1;
                    m_pk   = 2;
                    m_pa   = ad;
                    busy_q.push_back(ERASE_CYC);
                end
            end
            default: begin
                case (dd)
                    8'hFF: m_arr = 1;
                    8'h70: m_arr = 0;
                    8'h50: m_err = 8'h00;
                    8'h40, 8'h10: begin
                        m_phase = 1;
                        m_arr   = 0;
                    end
                    8'h20: begin
                        m_phase = 2;
                        m_arr   = 0;
                    end
                    default: ;
                endcase
            end
        endcase
    endtask

    task automatic model_complete();
        int base;
        if (m_pk == 1) begin
            mem_m[m_pa] = mem_m[m_pa] & m_pd;
        end else if (m_pk == 2) begin
            base = (int'(m_pa) / 16) * 16;
            for (int i = 0; i < 16; i++)
                mem_m[base + i] = 8'hFF;
        end
        m_pk   = 0;
        m_busy = 0;
        m_arr  = 0;
    endtask

    task automatic model_abort();
        m_arr   = 1;
        m_err   = 8'h00;
        m_phase = 0;
        m_busy  = 0;
        m_pk    = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] ad);
        if (m_arr && !m_busy)
            return mem_m[ad];
        return (m_busy ? 8'h00 : 8'h80) | m_err;
    endfunction

    task automatic bus_write(input logic [7:0] ad, input logic [7:0] dd);
        tick();
        a      = ad;
        tb_d   = dd;
        tb_drv = 1'b1;
        we     = 1'b0;
        repeat (4) tick();
        we = 1'b1;
        repeat (4) tick();
        tb_drv = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] ad, input logic [7:0] dd);
        model_write(ad, dd);
        bus_write(ad, dd);
    endtask

    task automatic bus_read(input logic [7:0] ad, input string name);
        exp_t e;
        e.is_sts = 0;
        e.val    = model_read(ad);
        e.name   = name;
        rd_q.push_back(e);
        tick();
        a      = ad;
        oe     = 1'b0;
        strobe = 1'b1;
        tick();
        oe     = 1'b1;
        strobe = 1'b0;
    endtask

    task automatic check_sts(input logic expv, input string name);
        exp_t e;
        e.is_sts = 1;
        e.val    = {7'b0, expv};
        e.name   = name;
        rd_q.push_back(e);
        tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (sts !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: NF_STS still %b after %0d cycles, expected 1", name, sts, n);
        end
        model_complete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        exp_t       e;
        int         op;
        logic [7:0] ra, rd, cm;

        for (int i = 0; i < 256; i++)
            mem_m[i] = 8'hFF;
        m_arr   = 1;
        m_phase = 0;
        m_err   = 8'h00;
        m_busy  = 0;
        m_pk    = 0;

        repeat (3) tick();
        rst = 1'b0;
        ce  = 1'b0;
        repeat (3) tick();

        bus_read(8'h05, "reset_read");
        check_sts(1'b1, "reset_sts");
        a      = 8'h05;
        tb_d   = 8'h5A;
        tb_drv = 1'b1;
        e.is_sts = 0;
        e.val    = 8'h5A;
        e.name   = "bus_float";
        rd_q.push_back(e);
        tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tb_drv = 1'b0;

        do_write(8'h00, 8'h40);
        do_write(8'h05, 8'h3C);
        bus_read(8'h05, "prog_busy_status");
        wait_ready("prog_ready");
        bus_read(8'h05, "prog_done_status");
        do_write(8'h00, 8'hFF);
        bus_read(8'h05, "prog_data");
        do_write(8'h00, 8'h10);
        do_write(8'h05, 8'hF0);
        wait_ready("prog2_ready");
        do_write(8'h00, 8'hFF);
        bus_read(8'h05, "prog_and");

        do_write(8'h00, 8'h40);
        do_write(8'h13, 8'h00);
        wait_ready("prog3_ready");
        do_write(8'h00, 8'h20);
        do_write(8'h13, 8'hD0);
        do_write(8'h00, 8'hFF);
        wait_ready("erase_ready");
        bus_read(8'h00, "erase_status");
        do_write(8'h00, 8'hFF);
        for (int i = 16; i < 32; i++)
            bus_read(8'(i), "erase_block");
        bus_read(8'h05, "erase_keep");

        wp = 1'b0;
        do_write(8'h00, 8'h40);
        do_write(8'h07, 8'h00);
        check_sts(1'b1, "wp_no_busy");
        bus_read(8'h07, "wp_status");
        do_write(8'h00, 8'hFF);
        bus_read(8'h07, "wp_keep");
        do_write(8'h00, 8'h50);
        do_write(8'h00, 8'h70);
        bus_read(8'h00, "clear_status");
        wp = 1'b1;

        do_write(8'h00, 8'h20);
        do_write(8'h00, 8'h55);
        bus_read(8'h00, "seq_error");
        do_write(8'h00, 8'h50);

        do_write(8'h00, 8'h20);
        do_write(8'h02, 8'hD0);
        busy_q[busy_q.size() - 1] = -1;
        repeat (5) tick();
        rp = 1'b0;
        repeat (4) tick();
        check_sts(1'b1, "abort_sts");
        rp = 1'b1;
        repeat (4) tick();
        model_abort();
        bus_read(8'h05, "abort_keep");
        bus_read(8'h02, "abort_mode");

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            ra = 8'($urandom);
            rd = 8'($urandom);
            wp = ($urandom_range(0, 7) != 0);
            case (op)
                0, 1: begin
                    do_write(ra, 8'h40);
                    do_write(ra, rd);
                end
                2: begin
                    do_write(ra, 8'h20);
                    do_write(ra, ($urandom_range(0, 3) == 0) ? rd : 8'hD0);
                end
                3: begin
                    case ($urandom_range(0, 3))
                        0:       cm = 8'hFF;
                        1:       cm = 8'h70;
                        2:       cm = 8'h50;
                        default: cm = 8'h33;
                    endcase
                    do_write(ra, cm);
                end
                4: bus_read(ra, "rnd_read");
                default: begin
                    do_write(ra, 8'hFF);
                    bus_read(ra, "rnd_array");
                end
            endcase
            if (m_busy)
                wait_ready("rnd_ready");
            bus_read(8'($urandom), "rnd_after");
        end
        wp = 1'b1;

        repeat (5) tick();
        checks++;
        if (rd_q.size() != 0 || busy_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads and %0d busy pulses outstanding, expected 0",
                     rd_q.size(), busy_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
